// File: rtl/scc_dac_out.sv
// scc_dac_out: output stage after the SCC channel mixer.
// Holds the mixed sample between strobes, applies a click-free mute fade
// (gain 0..256), exposes the post-gain level, and drives a first-order
// delta-sigma 1-bit stream for an external RC filter.
// Optional build macro: SCC_DAC_DITHER_EN adds a 16-bit Galois LFSR whose
// two low bits dither the modulator input.
//
// state    | meaning
// ---------+------------------------------------------------
// SILENT   | gain held at 0, waiting for mute=0
// FADE_IN  | gain steps +1 every 2^RAMP_SHIFT clocks
// PLAY     | gain held at 256, waiting for mute=1
// FADE_OUT | gain steps -1 every 2^RAMP_SHIFT clocks
module scc_dac_out #(
  parameter int RAMP_SHIFT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] sample_in,
  input  logic        sample_valid,
  input  logic        mute,
  output logic [10:0] level_out,
  output logic        ramp_busy,
  output logic        dac_out
);

  typedef enum logic [1:0] {
    SILENT   = 2'd0,
    FADE_IN  = 2'd1,
    PLAY     = 2'd2,
    FADE_OUT = 2'd3
  } state_t;

  localparam logic [8:0] PRESC_TC  = 9'((1 << RAMP_SHIFT) - 1);
  localparam logic [8:0] GAIN_FULL = 9'd256;

  state_t             r_state, w_state_nxt;
  logic [8:0]         r_gain, w_gain_nxt;
  logic [8:0]         r_presc, w_presc_nxt;
  logic               r_busy, w_busy_nxt;
  logic               w_step;
  logic signed [10:0] r_hold;
  logic signed [10:0] r_level;
  logic signed [20:0] w_prod;
  logic               w_unused_bits;
  logic [10:0]        w_u;
  logic [10:0]        r_acc;
  logic [11:0]        w_sum;
  logic               r_dac;

  // Sample hold register: last strobe wins, strobes ignored during reset.
  always_ff @(posedge clk) begin
    if (reset)             r_hold <= '0;
    else if (sample_valid) r_hold <= sample_in;
  end

  assign w_step = (r_presc == PRESC_TC);

  // Ramp FSM next-state, gain and prescaler; any state change clears the prescaler.
  always_comb begin
    w_state_nxt = r_state;
    w_gain_nxt  = r_gain;
    w_presc_nxt = '0;
    case (r_state)
      SILENT: begin
        if (!mute) w_state_nxt = FADE_IN;
      end
      FADE_IN: begin
        if (mute) begin
          w_state_nxt = FADE_OUT;
        end else if (r_gain == GAIN_FULL) begin
          // Re-entered from FADE_OUT before any step: already at full level.
          w_state_nxt = PLAY;
        end else if (w_step) begin
          w_gain_nxt = r_gain + 9'd1;
          if (r_gain == GAIN_FULL - 9'd1) w_state_nxt = PLAY;
        end else begin
          w_presc_nxt = r_presc + 9'd1;
        end
      end
      PLAY: begin
        if (mute) w_state_nxt = FADE_OUT;
      end
      FADE_OUT: begin
        if (!mute) begin
          w_state_nxt = FADE_IN;
        end else if (r_gain == 9'd0) begin
          // Re-entered from FADE_IN before any step: already silent.
          w_state_nxt = SILENT;
        end else if (w_step) begin
          w_gain_nxt = r_gain - 9'd1;
          if (r_gain == 9'd1) w_state_nxt = SILENT;
        end else begin
          w_presc_nxt = r_presc + 9'd1;
        end
      end
      default: w_state_nxt = SILENT;
    endcase
    w_busy_nxt = (w_state_nxt == FADE_IN) || (w_state_nxt == FADE_OUT);
  end

  // Ramp FSM state, gain, prescaler and busy flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SILENT;
      r_gain  <= '0;
      r_presc <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gain  <= w_gain_nxt;
      r_presc <= w_presc_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // |hold * gain / 256| never exceeds |hold|, so bits [18:8] carry the full result.
  assign w_prod        = r_hold * $signed({1'b0, r_gain});
  assign w_unused_bits = ^{w_prod[20:19], w_prod[7:0]};

  // Post-gain level register, arithmetic shift by 8 (floor).
  always_ff @(posedge clk) begin
    if (reset) r_level <= '0;
    else       r_level <= w_prod[18:8];
  end

  // Offset binary: level + 1024 is just the sign bit inverted.
  assign w_u = {~r_level[10], r_level[9:0]};

`ifdef SCC_DAC_DITHER_EN
  logic [15:0] r_lfsr;
  logic [11:0] w_ud;
  logic [10:0] w_uc;

  // Galois LFSR x^16+x^14+x^13+x^11, shifting right.
  always_ff @(posedge clk) begin
    if (reset) r_lfsr <= 16'hACE1;
    else       r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // Clamp so the dithered input never exceeds one carry per clock.
  assign w_ud  = {1'b0, w_u} + {10'd0, r_lfsr[1:0]};
  assign w_uc  = w_ud[11] ? 11'h7FF : w_ud[10:0];
  assign w_sum = {1'b0, r_acc} + {1'b0, w_uc};
`else
  assign w_sum = {1'b0, r_acc} + {1'b0, w_u};
`endif

  // Delta-sigma accumulator; the carry is the 1-bit output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
      r_dac <= 1'b0;
    end else begin
      r_acc <= w_sum[10:0];
      r_dac <= w_sum[11];
    end
  end

  assign level_out = r_level;
  assign ramp_busy = r_busy;
  assign dac_out   = r_dac;

endmodule

// File: tb/tb_scc_dac_out.sv
// Scoreboard bench for scc_dac_out (RAMP_SHIFT=4, default build).
module tb_scc_dac_out;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        mute = 1'b1;
  logic [10:0] level_out;
  logic        ramp_busy;
  logic        dac_out;

  scc_dac_out #(.RAMP_SHIFT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .mute         (mute),
    .level_out    (level_out),
    .ramp_busy    (ramp_busy),
    .dac_out      (dac_out)
  );

  always #5 clk = ~clk;

  localparam int SEL_LEVEL = 0;
  localparam int SEL_BUSY  = 1;
  localparam int SEL_DAC   = 2;
  localparam int SEL_HOLD  = 3;
  localparam int SEL_GAIN  = 4;
  localparam int SEL_STATE = 5;
  localparam int SEL_PRESC = 6;
  localparam int SEL_ONES  = 7;
  localparam int SEL_BLEN  = 8;
  localparam int SEL_REP   = 9;

  localparam int ST_SILENT = 0;
  localparam int ST_FIN    = 1;
  localparam int ST_PLAY   = 2;
  localparam int ST_FOUT   = 3;

  typedef struct {
    string name;
    int    sel;
    int    exp;
  } chk_t;

  chk_t q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   ones_cnt = 0;
  int   busy_cnt = 0;
  int   rep_cnt = 0;
  logic prev_dac = 1'b0;
  logic clr_meas = 1'b0;

  function automatic int pick(input int sel);
    case (sel)
      SEL_LEVEL: return int'($signed(level_out));
      SEL_BUSY:  return int'(ramp_busy);
      SEL_DAC:   return int'(dac_out);
      SEL_HOLD:  return int'($signed(dut.r_hold));
      SEL_GAIN:  return int'(dut.r_gain);
      SEL_STATE: return int'(dut.r_state);
      SEL_PRESC: return int'(dut.r_presc);
      SEL_ONES:  return ones_cnt;
      SEL_BLEN:  return busy_cnt;
      SEL_REP:   return rep_cnt;
      default:   return -99999;
    endcase
  endfunction

  // Monitor: drain pending expectations, then update the stream measurements.
  always @(negedge clk) begin
    chk_t e;
    int   act;
    while (q.size() > 0) begin
      e   = q.pop_front();
      act = pick(e.sel);
      n_vec++;
      if (act != e.exp) begin
        n_miss++;
        $display("FAIL %s: got %0d expected %0d (t=%0t)", e.name, act, e.exp, $time);
      end
    end
    if (clr_meas) begin
      ones_cnt = 0;
      busy_cnt = 0;
      rep_cnt  = 0;
    end else begin
      ones_cnt += int'(dac_out);
      busy_cnt += int'(ramp_busy);
      if (dac_out == prev_dac) rep_cnt++;
    end
    prev_dac = dac_out;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string nm, input int sel, input int e);
    chk_t c;
    c.name = nm;
    c.sel  = sel;
    c.exp  = e;
    q.push_back(c);
  endtask

  task automatic check_now(input string nm, input int sel, input int e);
    int got;
    got = pick(sel);
    n_vec++;
    if (got !== e) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, e, $time);
    end
  endtask

  task automatic density(input int val, input int exp_ones, input string nm);
    sample_valid = 1'b1;
    sample_in    = 11'(val);
    step();
    sample_valid = 1'b0;
    repeat (4) step();
    expect_val({nm, "_level"}, SEL_LEVEL, val);
    clr_meas = 1'b1;
    step();
    clr_meas = 1'b0;
    repeat (2048) step();
    expect_val({nm, "_ones"}, SEL_ONES, exp_ones);
  endtask

  task automatic tog_step();
    mute = ~mute;
    step();
  endtask

  initial begin
    // Reset with a strobe held active: nothing may be captured.
    reset        = 1'b1;
    sample_valid = 1'b1;
    sample_in    = 11'h3FF;
    mute         = 1'b1;
    repeat (3) step();
    check_now("rst_level", SEL_LEVEL, 0);
    check_now("rst_busy",  SEL_BUSY,  0);
    check_now("rst_dac",   SEL_DAC,   0);
    check_now("rst_hold",  SEL_HOLD,  0);
    check_now("rst_state", SEL_STATE, ST_SILENT);
    reset        = 1'b0;
    sample_valid = 1'b0;
    step();
    expect_val("rel_hold",  SEL_HOLD,  0);
    expect_val("rel_state", SEL_STATE, ST_SILENT);

    // Fade-in: 4096 busy clocks, ends at PLAY with full level.
    mute         = 1'b0;
    sample_valid = 1'b1;
    sample_in    = 11'd512;
    clr_meas     = 1'b1;
    step();
    sample_valid = 1'b0;
    clr_meas     = 1'b0;
    expect_val("fin_busy0",  SEL_BUSY,  1);
    expect_val("fin_hold",   SEL_HOLD,  512);
    expect_val("fin_state0", SEL_STATE, ST_FIN);
    repeat (4200) step();
    expect_val("fin_busy_len", SEL_BLEN,  4096);
    expect_val("fin_level",    SEL_LEVEL, 512);
    expect_val("fin_gain",     SEL_GAIN,  256);
    expect_val("fin_state",    SEL_STATE, ST_PLAY);
    expect_val("fin_busy",     SEL_BUSY,  0);

    // Modulator density at full gain.
    density(0, 1024, "dens_zero");
    expect_val("dens_zero_alt", SEL_REP, 0);
    density(-1024, 0, "dens_min");
    density(1023, 2047, "dens_max");

    // Rounding at gain 128: fade out from 256 for 128 steps, then freeze by toggling mute.
    mute = 1'b1;
    step();
    repeat (2048) step();
    expect_val("rnd_gain_reach",  SEL_GAIN,  128);
    expect_val("rnd_state_reach", SEL_STATE, ST_FOUT);
    mute = 1'b0;
    step();
    expect_val("rnd_rev_state", SEL_STATE, ST_FIN);
    sample_valid = 1'b1;
    sample_in    = 11'(-3);
    tog_step();
    sample_valid = 1'b0;
    repeat (3) tog_step();
    expect_val("rnd_neg3",  SEL_LEVEL, -2);
    expect_val("rnd_gain1", SEL_GAIN,  128);
    sample_valid = 1'b1;
    sample_in    = 11'd3;
    tog_step();
    sample_valid = 1'b0;
    repeat (3) tog_step();
    expect_val("rnd_pos3",  SEL_LEVEL, 1);
    expect_val("rnd_gain2", SEL_GAIN,  128);

    // Reset mid-fade with a strobe present.
    reset        = 1'b1;
    mute         = 1'b1;
    sample_valid = 1'b1;
    sample_in    = 11'd100;
    step();
    expect_val("mrst_state", SEL_STATE, ST_SILENT);
    expect_val("mrst_gain",  SEL_GAIN,  0);
    expect_val("mrst_presc", SEL_PRESC, 0);
    expect_val("mrst_level", SEL_LEVEL, 0);
    expect_val("mrst_busy",  SEL_BUSY,  0);
    expect_val("mrst_dac",   SEL_DAC,   0);
    expect_val("mrst_hold",  SEL_HOLD,  0);
    reset        = 1'b0;
    sample_valid = 1'b0;
    step();

    // Fade reversal at gain 100, then fade out to zero in 1600 clocks.
    mute = 1'b0;
    step();
    repeat (1600) step();
    expect_val("rev_gain_reach", SEL_GAIN,  100);
    expect_val("rev_state_fin",  SEL_STATE, ST_FIN);
    mute = 1'b1;
    step();
    expect_val("rev_state", SEL_STATE, ST_FOUT);
    expect_val("rev_gain",  SEL_GAIN,  100);
    expect_val("rev_presc", SEL_PRESC, 0);
    expect_val("rev_busy",  SEL_BUSY,  1);
    repeat (1599) step();
    expect_val("rev_gain_last", SEL_GAIN, 1);
    expect_val("rev_busy_last", SEL_BUSY, 1);
    step();
    check_now("rev_gain_end",  SEL_GAIN,  0);
    check_now("rev_busy_end",  SEL_BUSY,  0);
    check_now("rev_state_end", SEL_STATE, ST_SILENT);

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
